ysyx_24100006_ifu_axi_master: RTL and testbench
===============================================

Name: ysyx_24100006_ifu_axi_master

Overview:
- AXI4-Lite read initiator for the IF stage: owns the PC register and issues one instruction fetch per PC.
- Drives AR/R toward the instruction memory responder and presents each fetched instruction to ID through a valid/ready handshake.
- Waits for the next PC from the later pipeline stages, then fetches again.
- The write channels are tied off, since instruction fetch is read-only.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded at reset; first fetch address.
- ADDR_W, 32, address and PC width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- axi_araddr  out  ADDR_W  read address; equals PC register.
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address ready from responder.
- axi_rdata  in  DATA_W  read data.
- axi_rresp  in  2  read response; nonzero = error.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  read data ready.
- axi_awvalid  out  1  constant 0.
- axi_wvalid  out  1  constant 0.
- axi_wdata  out  DATA_W  constant 0.
- axi_bready  out  1  constant 1.
- inst  out  DATA_W  latched instruction.
- inst_pc  out  ADDR_W  PC of inst.
- inst_err  out  1  latched rresp != 0 for inst.
- inst_valid  out  1  inst/inst_pc/inst_err valid to ID.
- inst_ready  in  1  ID accepts instruction.
- npc  in  ADDR_W  next PC from EX/WB.
- npc_valid  in  1  npc valid; one-cycle pulse or level.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, pc=RESET_PC, axi_arvalid=0, axi_rready=0, inst_valid=0, inst=0, inst_err=0.
- Reset asserted mid-transaction aborts it immediately; all outputs return to reset values. Any in-flight responder beat after reset is not consumed.
- inst_pc always equals pc; axi_araddr always equals pc.
- States:
  - IDLE: first edge after reset deasserts -> arvalid<=1, go AR.
  - AR: arvalid held 1 and araddr held stable until an edge where arvalid && arready. At that edge: arvalid<=0, rready<=1, go R. arvalid is never dropped without a handshake.
  - R: rready held 1. On an edge with rvalid && rready: inst<=rdata, inst_err<=(rresp!=0), rready<=0, inst_valid<=1, go OUT.
  - OUT: inst_valid held 1; inst, inst_err and pc stable. On an edge with inst_valid && inst_ready: inst_valid<=0, go WAIT_NPC.
  - WAIT_NPC: on an edge with npc_valid: pc<=npc, arvalid<=1, go AR. npc_valid in any other state is ignored; the pipeline waits for WAIT_NPC.
- Handshake rules: ar and r never both asserted in the same cycle. arvalid does not depend on arready. rready is asserted only in R.
- Latency with a responder that raises arready 1 cycle after arvalid and rvalid 1 cycle after the AR handshake: arvalid rise -> inst_valid rise = 3 cycles. An rvalid arriving in the same cycle rready rises is accepted on that edge.
- pc is held exactly (no increment or wrap logic here); npc=32'hFFFF_FFFC is fetched as given.
- Misaligned npc (bits[1:0]!=0) is passed through unchanged; alignment checking belongs to EX.
- inst_err does not stop the FSM; ID decides the trap.
- No outstanding-transaction count above 1.

Test Plan:
- Reset release, responder arready delay 1, rdata=32'h0000_0413, rresp=0, inst_ready=1 -> araddr=32'h8000_0000; inst_valid rises 3 cycles after arvalid with inst=32'h0000_0413, inst_pc=32'h8000_0000, inst_err=0.
- arready delayed 5 cycles -> arvalid and araddr stay constant for all 5 cycles; exactly one AR handshake; rready low until after the handshake.
- inst_ready held 0 for 4 cycles after inst_valid -> inst and inst_valid stable; no new arvalid; the 4 cycles of npc_valid pulses are ignored; inst_ready=1 then npc_valid=1 with npc=32'h8000_0004 -> next araddr=32'h8000_0004.
- rresp=2'b10, rdata=32'hDEAD_BEEF -> inst=32'hDEAD_BEEF, inst_err=1; the next fetch clears inst_err when rresp=0.
- Reset asserted while in R (rready=1) -> rready, arvalid and inst_valid drop to 0 asynchronously before the next edge; pc=32'h8000_0000; the fetch restarts after release.
- Write-channel check: over the whole run awvalid=0, wvalid=0, wdata=0, bready=1.

Source files
------------

// File: rtl/ysyx_24100006_ifu_axi_master.sv
// ysyx_24100006_ifu_axi_master: IF-stage AXI4-Lite read initiator, one fetch per PC.
// Rev 1.0
`default_nettype none

module ysyx_24100006_ifu_axi_master #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic              axi_awvalid,
  output logic              axi_wvalid,
  output logic [DATA_W-1:0] axi_wdata,
  output logic              axi_bready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [ADDR_W-1:0] npc,
  input  logic              npc_valid
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AR       = 3'd1,
    R        = 3'd2,
    OUT      = 3'd3,
    WAIT_NPC = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;

  assign axi_araddr  = r_pc;
  assign inst_pc     = r_pc;

  // Fetch is read-only; the write channels are parked.
  assign axi_awvalid = 1'b0;
  assign axi_wvalid  = 1'b0;
  assign axi_wdata   = '0;
  assign axi_bready  = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          axi_arvalid <= 1'b1;
          r_state     <= AR;
        end
        AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            r_state     <= R;
          end
        end
        R: begin
          if (axi_rvalid) begin
            inst       <= axi_rdata;
            inst_err   <= (axi_rresp != 2'b00);
            axi_rready <= 1'b0;
            inst_valid <= 1'b1;
            r_state    <= OUT;
          end
        end
        OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            r_state    <= WAIT_NPC;
          end
        end
        WAIT_NPC: begin
          // npc is taken verbatim; alignment is EX's concern.
          if (npc_valid) begin
            r_pc        <= npc;
            axi_arvalid <= 1'b1;
            r_state     <= AR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_ifu_axi_master.sv
// Scoreboard bench for ysyx_24100006_ifu_axi_master with a small AXI read responder model.
`default_nettype none

module tb_ysyx_24100006_ifu_axi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        awvalid, wvalid, bready;
  logic [31:0] wdata;
  logic [31:0] inst, inst_pc;
  logic        inst_err, inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] npc = '0;
  logic        npc_valid = 1'b0;

  ysyx_24100006_ifu_axi_master dut (
    .clk(clk), .reset(reset),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .axi_awvalid(awvalid), .axi_wvalid(wvalid), .axi_wdata(wdata), .axi_bready(bready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .npc(npc), .npc_valid(npc_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ar_delay = 1;
  int          ar_cnt = 0;
  int          ar_hs = 0;
  int          r_hs = 0;
  bit          r_hold = 1'b0;
  logic [31:0] resp_data = '0;
  logic [1:0]  resp_resp = '0;
  logic        iv_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Responder: arready after ar_delay cycles of arvalid, rvalid in the cycle rready rises.
  always @(negedge clk) begin
    if (arready && !arvalid) ar_hs++;
    if (rvalid && !rready) r_hs++;
    if (arvalid) begin
      if (ar_cnt >= ar_delay) arready = 1'b1;
      else begin
        arready = 1'b0;
        ar_cnt++;
      end
    end else begin
      arready = 1'b0;
      ar_cnt  = 0;
    end
    rvalid = rready && !r_hold;
    rdata  = resp_data;
    rresp  = resp_resp;
  end

  // Monitor: compares each presented instruction against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    check("wr_tieoff", {29'd0, awvalid, wvalid, bready, wdata}, {29'd0, 1'b0, 1'b0, 1'b1, 32'h0});
    check("ar_r_excl", {63'd0, arvalid && rready}, 64'd0);
    if (inst_valid && !iv_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst", {32'd0, inst}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("inst", {32'd0, inst}, {32'd0, e.inst});
        check("inst_pc", {32'd0, inst_pc}, {32'd0, e.pc});
        check("inst_err", {63'd0, inst_err}, {63'd0, e.err});
      end
    end
    iv_prev = inst_valid;
  end

  task automatic wait_for(input int sel, input string name, output int at);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      case (sel)
        0:       seen = arvalid;
        1:       seen = inst_valid;
        default: seen = rready;
      endcase
      if (seen) break;
    end
    at = cyc;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: got timeout want event", name);
    end
  endtask

  task automatic issue_npc(input logic [31:0] a, output int at);
    npc       = a;
    npc_valid = 1'b1;
    wait_for(0, "npc_arvalid", at);
    npc_valid = 1'b0;
    check("araddr", {32'd0, araddr}, {32'd0, a});
  endtask

  task automatic expect_fetch(input logic [31:0] d, input logic [1:0] rsp, input logic [31:0] pc);
    resp_data = d;
    resp_resp = rsp;
    exp_q.push_back('{inst: d, pc: pc, err: (rsp != 2'b00)});
  endtask

  task automatic accept_done;
    @(negedge clk);
    check("inst_valid_drop", {63'd0, inst_valid}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_ar, t_iv, hs0;

    repeat (2) @(negedge clk);
    check("rst_arvalid", {63'd0, arvalid}, 64'd0);
    check("rst_rready", {63'd0, rready}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_inst", {32'd0, inst}, 64'd0);
    check("rst_inst_err", {63'd0, inst_err}, 64'd0);
    check("rst_pc", {32'd0, inst_pc}, 64'h8000_0000);

    // First fetch and latency from arvalid rise to inst_valid rise.
    expect_fetch(32'h0000_0413, 2'b00, 32'h8000_0000);
    reset = 1'b0;
    wait_for(0, "first_arvalid", t_ar);
    check("first_araddr", {32'd0, araddr}, 64'h8000_0000);
    wait_for(1, "first_inst", t_iv);
    check("latency", 64'(t_iv - t_ar), 64'd3);
    accept_done();

    // Slow arready: address phase held steady with a single handshake.
    ar_delay = 5;
    hs0 = ar_hs;
    expect_fetch(32'h0010_0093, 2'b00, 32'h8000_0010);
    issue_npc(32'h8000_0010, t_ar);
    for (int i = 0; i < 5; i++) begin
      check("hold_arvalid", {63'd0, arvalid}, 64'd1);
      check("hold_araddr", {32'd0, araddr}, 64'h8000_0010);
      check("hold_rready", {63'd0, rready}, 64'd0);
      @(negedge clk);
    end
    wait_for(1, "slow_inst", t_iv);
    check("one_ar_hs", 64'(ar_hs - hs0), 64'd1);
    accept_done();
    ar_delay = 1;

    // Back-pressure from ID with npc pulses that must be ignored.
    inst_ready = 1'b0;
    expect_fetch(32'h0000_0013, 2'b00, 32'h8000_0020);
    issue_npc(32'h8000_0020, t_ar);
    wait_for(1, "bp_inst", t_iv);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", {63'd0, inst_valid}, 64'd1);
      check("bp_inst", {32'd0, inst}, 64'h0000_0013);
      check("bp_pc", {32'd0, inst_pc}, 64'h8000_0020);
      check("bp_no_ar", {63'd0, arvalid}, 64'd0);
      npc       = 32'h1234_5678;
      npc_valid = 1'b1;
      @(negedge clk);
    end
    npc_valid  = 1'b0;
    check("bp_valid_end", {63'd0, inst_valid}, 64'd1);
    inst_ready = 1'b1;
    accept_done();
    check("bp_ignored_npc", {32'd0, araddr}, 64'h8000_0020);

    // Error response, then a clean fetch clears inst_err.
    expect_fetch(32'hDEAD_BEEF, 2'b10, 32'h8000_0004);
    issue_npc(32'h8000_0004, t_ar);
    wait_for(1, "err_inst", t_iv);
    accept_done();
    expect_fetch(32'h0000_8067, 2'b00, 32'hFFFF_FFFC);
    issue_npc(32'hFFFF_FFFC, t_ar);
    wait_for(1, "clr_inst", t_iv);
    accept_done();

    // Reset while waiting in R aborts asynchronously and restarts at RESET_PC.
    r_hold = 1'b1;
    issue_npc(32'h8000_000E, t_ar);
    wait_for(2, "r_phase", t_ar);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rready", {63'd0, rready}, 64'd0);
    check("arst_arvalid", {63'd0, arvalid}, 64'd0);
    check("arst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("arst_pc", {32'd0, araddr}, 64'h8000_0000);
    @(negedge clk);
    r_hold = 1'b0;
    expect_fetch(32'h0040_0113, 2'b00, 32'h8000_0000);
    reset = 1'b0;
    wait_for(0, "restart_arvalid", t_ar);
    check("restart_araddr", {32'd0, araddr}, 64'h8000_0000);
    wait_for(1, "restart_inst", t_iv);
    accept_done();

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("ar_hs_total", 64'(ar_hs), 64'd7);
    check("r_hs_total", 64'(r_hs), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
